brush_stamp_engine: RTL

Parametrised successor to the single-pixel packet generator in the Tiny Canvas paint pipeline. Accepts one stamp request (centre, colour, brush size, symmetry mode) over a valid/ready handshake. Streams every on-canvas pixel of the square brush footprint and its mirror images, applying clipping and mirror de-duplication. Sits between the pixel-source mux (freehand/fill) and the undo/redo buffer and I2C transmit path, with backpressure on both sides.

---
 rtl/paint_pkg.sv | 22 ++
 rtl/brush_stamp_engine_if.sv | 34 +++
 rtl/stamp_point_gen.sv | 59 +++++
 rtl/brush_stamp_engine.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/paint_pkg.sv
// Shared definitions for the Tiny Canvas paint pipeline: symmetry modes, colour width
// and the per-mode mirror copy count.
package paint_pkg;
    localparam int COLOR_W         = 3;
    localparam int DEFAULT_COORD_W = 8;

    typedef enum logic [1:0] {
        SYM_NONE = 2'd0,
        SYM_X    = 2'd1,
        SYM_Y    = 2'd2,
        SYM_QUAD = 2'd3
    } sym_mode_e;

    // Index of the final copy emitted for each base point in the given mode.
    function automatic logic [1:0] last_copy(input sym_mode_e mode);
        case (mode)
            SYM_NONE:     return 2'd0;
            SYM_X, SYM_Y: return 2'd1;
            default:      return 2'd3;
        endcase
    endfunction
endpackage

// File: rtl/brush_stamp_engine_if.sv
// Request and pixel handshake bundle of the brush stamp engine. Both sides use
// valid/ready: a transfer happens on a rising edge where valid && ready are both high.
interface brush_stamp_engine_if
    import paint_pkg::*;
#(
    parameter int COORD_W = DEFAULT_COORD_W,
    parameter int SIZE_W  = 3
) ();
    logic               in_valid;
    logic               in_ready;
    logic [COORD_W-1:0] in_x;
    logic [COORD_W-1:0] in_y;
    logic [COLOR_W-1:0] in_color;
    logic [SIZE_W-1:0]  brush_size;
    logic [1:0]         symmetry_mode;
    logic               flush;
    logic               out_valid;
    logic               out_ready;
    logic [COORD_W-1:0] out_x;
    logic [COORD_W-1:0] out_y;
    logic [COLOR_W-1:0] out_color;
    logic               busy;
    logic               stamp_done;

    modport slave (
        input  in_valid, in_x, in_y, in_color, brush_size, symmetry_mode, flush, out_ready,
        output in_ready, out_valid, out_x, out_y, out_color, busy, stamp_done
    );

    modport master (
        output in_valid, in_x, in_y, in_color, brush_size, symmetry_mode, flush, out_ready,
        input  in_ready, out_valid, out_x, out_y, out_color, busy, stamp_done
    );
endinterface

// File: rtl/stamp_point_gen.sv
// Maps one footprint candidate (base point + copy index) to its canvas coordinate and
// decides whether it is emitted (on canvas, and not a repeat of an earlier copy).
module stamp_point_gen
    import paint_pkg::*;
#(
    parameter int COORD_W  = DEFAULT_COORD_W,
    parameter int CANVAS_W = 256,
    parameter int CANVAS_H = 256
) (
    input  logic signed [COORD_W+1:0] cx_i,
    input  logic signed [COORD_W+1:0] cy_i,
    input  logic [1:0]                copy_i,
    input  sym_mode_e                 mode_i,
    output logic [COORD_W-1:0]        x_o,
    output logic [COORD_W-1:0]        y_o,
    output logic                      emit_o
);
    localparam logic [COORD_W:0] X_MAX = (COORD_W+1)'(CANVAS_W - 1);
    localparam logic [COORD_W:0] Y_MAX = (COORD_W+1)'(CANVAS_H - 1);

    logic [COORD_W:0] bx, by, mx, my;
    logic             in_range, mx_same, my_same, use_mx, use_my, dup;

    assign bx       = cx_i[COORD_W:0];
    assign by       = cy_i[COORD_W:0];
    assign in_range = !cx_i[COORD_W+1] && (bx <= X_MAX) && !cy_i[COORD_W+1] && (by <= Y_MAX);
    assign mx       = X_MAX - bx;
    assign my       = Y_MAX - by;
    // A mirror lands on its own base point when the point sits on the mirror axis.
    assign mx_same  = (mx == bx);
    assign my_same  = (my == by);

    always_comb begin
        use_mx = 1'b0;
        use_my = 1'b0;
        dup    = 1'b0;
        case (mode_i)
            SYM_X: if (copy_i == 2'd1) begin
                use_mx = 1'b1;
                dup    = mx_same;
            end
            SYM_Y: if (copy_i == 2'd1) begin
                use_my = 1'b1;
                dup    = my_same;
            end
            SYM_QUAD: case (copy_i)
                2'd1: begin use_mx = 1'b1; dup = mx_same; end
                2'd2: begin use_my = 1'b1; dup = my_same; end
                2'd3: begin use_mx = 1'b1; use_my = 1'b1; dup = mx_same || my_same; end
                default: ;
            endcase
            default: ;
        endcase
    end

    assign x_o    = use_mx ? mx[COORD_W-1:0] : bx[COORD_W-1:0];
    assign y_o    = use_my ? my[COORD_W-1:0] : by[COORD_W-1:0];
    assign emit_o = in_range && !dup;
endmodule

// File: rtl/brush_stamp_engine.sv
// Expands one accepted stamp request into a stream of brush-footprint pixels and their
// mirror images, one candidate per cycle, with clipped or duplicate candidates skipped.
module brush_stamp_engine
    import paint_pkg::*;
#(
    parameter int COORD_W  = DEFAULT_COORD_W,
    parameter int CANVAS_W = 256,
    parameter int CANVAS_H = 256,
    parameter int MAX_SIZE = 7,
    parameter int SIZE_W   = $clog2(MAX_SIZE + 1)
) (
    input logic           clk,
    input logic           rst_n,
    brush_stamp_engine_if.slave bus
);
    localparam logic [0:0]        ST_IDLE = 1'b0;
    localparam logic [0:0]        ST_EMIT = 1'b1;
    localparam logic [SIZE_W-1:0] MAX_S   = SIZE_W'(MAX_SIZE);
    localparam logic signed [SIZE_W:0] ONE_S = (SIZE_W+1)'(1);
    localparam int EXT_W = COORD_W + 1 - SIZE_W;

    logic [0:0]               state_q, state_d;
    logic [COORD_W-1:0]       x_q, x_d, y_q, y_d;
    logic [COLOR_W-1:0]       color_q, color_d;
    logic [SIZE_W-1:0]        s_q, s_d, s_req;
    sym_mode_e                mode_q, mode_d;
    logic signed [SIZE_W:0]   dx_q, dx_d, dy_q, dy_d, s_pos, s_neg_req;
    logic [1:0]               copy_q, copy_d;
    logic                     out_valid_q, out_valid_d, stamp_done_q, stamp_done_d;
    logic [COORD_W-1:0]       out_x_q, out_x_d, out_y_q, out_y_d;
    logic                     accept, advance, last_cand, emit_load;
    logic signed [COORD_W+1:0] cx_g, cy_g;
    logic [COORD_W-1:0]       gen_x, gen_y;
    logic                     gen_emit;

    assign s_req     = (bus.brush_size > MAX_S) ? MAX_S : bus.brush_size;
    assign s_neg_req = -$signed({1'b0, s_req});
    assign s_pos     = $signed({1'b0, s_q});
    assign accept    = (state_q == ST_IDLE) && bus.in_valid && !bus.flush;
    // A skipped candidate (out_valid low) moves on without waiting for out_ready.
    assign advance   = (state_q == ST_EMIT) && (!out_valid_q || bus.out_ready);
    assign last_cand = (dy_q == s_pos) && (dx_q == s_pos) && (copy_q == last_copy(mode_q));

    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        color_d      = color_q;
        s_d          = s_q;
        mode_d       = mode_q;
        dx_d         = dx_q;
        dy_d         = dy_q;
        copy_d       = copy_q;
        stamp_done_d = 1'b0;
        emit_load    = 1'b0;
        if (bus.flush) begin
            state_d = ST_IDLE;
        end else if (accept) begin
            state_d   = ST_EMIT;
            x_d       = bus.in_x;
            y_d       = bus.in_y;
            color_d   = bus.in_color;
            s_d       = s_req;
            mode_d    = sym_mode_e'(bus.symmetry_mode);
            dx_d      = s_neg_req;
            dy_d      = s_neg_req;
            copy_d    = 2'd0;
            emit_load = 1'b1;
        end else if (advance) begin
            if (last_cand) begin
                state_d      = ST_IDLE;
                stamp_done_d = 1'b1;
            end else begin
                emit_load = 1'b1;
                if (copy_q != last_copy(mode_q)) begin
                    copy_d = copy_q + 2'd1;
                end else begin
                    copy_d = 2'd0;
                    if (dx_q != s_pos) begin
                        dx_d = dx_q + ONE_S;
                    end else begin
                        dx_d = -s_pos;
                        dy_d = dy_q + ONE_S;
                    end
                end
            end
        end
    end

    // The point generator looks at the candidate about to be presented, so every
    // pixel output comes straight from a flop.
    assign cx_g = $signed({2'b00, x_d}) + $signed({{EXT_W{dx_d[SIZE_W]}}, dx_d});
    assign cy_g = $signed({2'b00, y_d}) + $signed({{EXT_W{dy_d[SIZE_W]}}, dy_d});

    stamp_point_gen #(
        .COORD_W (COORD_W),
        .CANVAS_W(CANVAS_W),
        .CANVAS_H(CANVAS_H)
    ) u_point_gen (
        .cx_i  (cx_g),
        .cy_i  (cy_g),
        .copy_i(copy_d),
        .mode_i(mode_d),
        .x_o   (gen_x),
        .y_o   (gen_y),
        .emit_o(gen_emit)
    );

    always_comb begin
        out_valid_d = out_valid_q;
        out_x_d     = out_x_q;
        out_y_d     = out_y_q;
        if (emit_load) begin
            out_valid_d = gen_emit;
            out_x_d     = gen_x;
            out_y_d     = gen_y;
        end else if (state_d == ST_IDLE) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            x_q          <= '0;
            y_q          <= '0;
            color_q      <= '0;
            s_q          <= '0;
            mode_q       <= SYM_NONE;
            dx_q         <= '0;
            dy_q         <= '0;
            copy_q       <= '0;
            out_valid_q  <= 1'b0;
            out_x_q      <= '0;
            out_y_q      <= '0;
            stamp_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            color_q      <= color_d;
            s_q          <= s_d;
            mode_q       <= mode_d;
            dx_q         <= dx_d;
            dy_q         <= dy_d;
            copy_q       <= copy_d;
            out_valid_q  <= out_valid_d;
            out_x_q      <= out_x_d;
            out_y_q      <= out_y_d;
            stamp_done_q <= stamp_done_d;
        end
    end

    // flush wins over a same-cycle request, so the engine never offers itself then.
    assign bus.in_ready   = (state_q == ST_IDLE) && !bus.flush;
    assign bus.busy       = (state_q == ST_EMIT);
    assign bus.out_valid  = out_valid_q;
    assign bus.out_x      = out_x_q;
    assign bus.out_y      = out_y_q;
    assign bus.out_color  = color_q;
    assign bus.stamp_done = stamp_done_q;
endmodule
